// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: TX/RX byte FIFOs between the UART register decoder and the UART core.
// Define UART_RX_DROP_EN to drop RX bytes on overflow (sticky rx_overflow) instead of backpressuring.
module uart_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cpu_tx_data,
  input  logic                  cpu_tx_valid,
  output logic                  cpu_tx_ready,
  output logic [7:0]            cpu_rx_data,
  output logic                  cpu_rx_valid,
  input  logic                  cpu_rx_ready,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_valid,
  input  logic                  uart_tx_ready,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_valid,
  output logic                  uart_rx_ready,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  rx_overflow,
  input  logic                  clr_overflow
);
  localparam int PW = DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = CW'(DEPTH);
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  tx_state_t tx_state, tx_next;
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic tx_push, tx_pop, tx_avail, rx_push, rx_pop, rx_full, drop;
  assign tx_avail = tx_count != '0;
  assign cpu_tx_ready = tx_count != FULL;
  assign tx_push = cpu_tx_valid && cpu_tx_ready;
  always_comb begin
    tx_next = tx_state == TX_IDLE ? (tx_avail ? TX_SEND : TX_IDLE)
                                  : ((uart_tx_ready && !tx_avail) ? TX_IDLE : TX_SEND);
    tx_pop = tx_avail && (tx_state == TX_IDLE || uart_tx_ready);
    uart_tx_valid = tx_state == TX_SEND;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_wp <= '0;
      tx_rp <= '0;
      tx_count <= '0;
      uart_tx_data <= 8'h00;
    end else begin
      tx_state <= tx_next;
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop) begin
        tx_rp <= tx_rp + PW'(1);
        uart_tx_data <= tx_mem[tx_rp];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= cpu_tx_data;
    if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
  end
  assign rx_full = rx_count == FULL;
  assign cpu_rx_valid = rx_count != '0;
  assign cpu_rx_data = cpu_rx_valid ? rx_mem[rx_rp] : 8'h00;
  assign rx_pop = cpu_rx_valid && cpu_rx_ready;
`ifdef UART_RX_DROP_EN
  // A pop on the same edge frees the slot the arriving byte needs.
  assign uart_rx_ready = 1'b1;
  assign rx_push = uart_rx_valid && (!rx_full || rx_pop);
  assign drop = uart_rx_valid && rx_full && !rx_pop;
`else
  assign uart_rx_ready = !rx_full;
  assign rx_push = uart_rx_valid && uart_rx_ready;
  assign drop = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_count <= '0;
      rx_overflow <= 1'b0;
    end else begin
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop) rx_rp <= rx_rp + PW'(1);
      rx_overflow <= drop ? 1'b1 : (clr_overflow ? 1'b0 : rx_overflow);
    end
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: scoreboard bench; stimulus queues expected bytes, a monitor checks each handshake.
module tb_uart_fifo_ctrl;
  logic clk = 0, rst_n = 0;
  logic [7:0] cpu_tx_data = 0, cpu_rx_data, uart_tx_data, uart_rx_data = 0;
  logic cpu_tx_valid = 0, cpu_tx_ready, cpu_rx_valid, cpu_rx_ready = 0;
  logic uart_tx_valid, uart_tx_ready = 0, uart_rx_valid = 0, uart_rx_ready;
  logic [3:0] tx_count, rx_count;
  logic rx_overflow, clr_overflow = 0;
  int checks = 0, errors = 0;
  logic [7:0] tx_q[$], rx_q[$];

  uart_fifo_ctrl #(.DEPTH_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_tx_data(cpu_tx_data), .cpu_tx_valid(cpu_tx_valid), .cpu_tx_ready(cpu_tx_ready),
    .cpu_rx_data(cpu_rx_data), .cpu_rx_valid(cpu_rx_valid), .cpu_rx_ready(cpu_rx_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .rx_overflow(rx_overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes complete on the next rising edge; inputs are stable by the falling edge.
  always @(negedge clk) begin
    if (rst_n && uart_tx_valid && uart_tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got %0h expected none", uart_tx_data);
      end else chk("tx_data", {24'h0, uart_tx_data}, {24'h0, tx_q.pop_front()});
    end
    if (rst_n && cpu_rx_valid && cpu_rx_ready) begin
      if (rx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected: got %0h expected none", cpu_rx_data);
      end else chk("rx_data", {24'h0, cpu_rx_data}, {24'h0, rx_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_tx_valid", uart_tx_valid, 0);
    chk("rst_tx_data", uart_tx_data, 0);
    chk("rst_cpu_tx_ready", cpu_tx_ready, 1);
    chk("rst_cpu_rx_valid", cpu_rx_valid, 0);
    chk("rst_cpu_rx_data", cpu_rx_data, 0);
    chk("rst_uart_rx_ready", uart_rx_ready, 1);
    chk("rst_overflow", rx_overflow, 0);
    chk("rst_counts", {tx_count, rx_count}, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    // single byte, held while the core stalls
    cpu_tx_data = 8'h41; cpu_tx_valid = 1; tx_q.push_back(8'h41);
    tick();
    cpu_tx_valid = 0;
    chk("lat_not_yet", uart_tx_valid, 0);
    tick();
    chk("lat_valid", uart_tx_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", uart_tx_data, 8'h41);
      tick();
    end
    uart_tx_ready = 1;
    tick();
    uart_tx_ready = 0;
    chk("idle_after_send", uart_tx_valid, 0);
    chk("tx_count_zero", tx_count, 0);
    // fill to 9 bytes total, 10th refused
    for (int i = 0; i < 10; i++) begin
      cpu_tx_data = 8'(i); cpu_tx_valid = 1;
      if (i < 9) tx_q.push_back(8'(i));
      tick();
      if (i == 8) begin
        chk("tx_full_ready", cpu_tx_ready, 0);
        chk("tx_full_count", tx_count, 8);
      end
    end
    cpu_tx_valid = 0;
    chk("tx_10th_ignored", tx_count, 8);
    uart_tx_ready = 1;
    for (int i = 0; i < 9; i++) begin
      chk("tx_no_bubble", uart_tx_valid, 1);
      tick();
    end
    chk("tx_drained", {uart_tx_valid, tx_count}, 0);
    uart_tx_ready = 0;
    // basic RX
    uart_rx_valid = 1; uart_rx_data = 8'h55; rx_q.push_back(8'h55);
    tick();
    uart_rx_data = 8'hAA; rx_q.push_back(8'hAA);
    tick();
    uart_rx_valid = 0;
    chk("rx_valid", cpu_rx_valid, 1);
    chk("rx_head", cpu_rx_data, 8'h55);
    cpu_rx_ready = 1;
    tick();
    chk("rx_head2", cpu_rx_data, 8'hAA);
    tick();
    chk("rx_empty_valid", cpu_rx_valid, 0);
    chk("rx_empty_data", cpu_rx_data, 0);
    tick();
    cpu_rx_ready = 0;
    chk("rx_empty_pop", rx_count, 0);
    // RX full
    for (int i = 0; i < 8; i++) begin
      uart_rx_valid = 1; uart_rx_data = 8'h60 + 8'(i); rx_q.push_back(8'h60 + 8'(i));
      tick();
    end
    uart_rx_data = 8'h99;
    tick();
    chk("rx_full_count", rx_count, 8);
`ifdef UART_RX_DROP_EN
    chk("rx_drop_ready", uart_rx_ready, 1);
    chk("rx_overflow_set", rx_overflow, 1);
    clr_overflow = 1;
    tick();
    chk("rx_overflow_set_wins", rx_overflow, 1);
    uart_rx_valid = 0;
    tick();
    clr_overflow = 0;
    chk("rx_overflow_clr", rx_overflow, 0);
    for (int i = 0; i < 8; i++) begin
      cpu_rx_ready = 1;
      tick();
    end
`else
    chk("rx_backpressure", uart_rx_ready, 0);
    chk("rx_overflow_tied", rx_overflow, 0);
    cpu_rx_ready = 1;
    tick();
    cpu_rx_ready = 0;
    chk("rx_after_pop", {uart_rx_ready, rx_count}, {1'b1, 4'd7});
    rx_q.push_back(8'h99);
    tick();
    uart_rx_valid = 0;
    chk("rx_99_accepted", rx_count, 8);
    cpu_rx_ready = 1;
    for (int i = 0; i < 8; i++) tick();
`endif
    cpu_rx_ready = 0;
    chk("rx_full_drained", rx_count, 0);
    // simultaneous push/pop across pointer wrap
    for (int i = 0; i < 3; i++) begin
      uart_rx_valid = 1; uart_rx_data = 8'h30 + 8'(i); rx_q.push_back(8'h30 + 8'(i));
      tick();
    end
    cpu_rx_ready = 1;
    for (int i = 0; i < 20; i++) begin
      uart_rx_data = 8'h12 + 8'(i); rx_q.push_back(8'h12 + 8'(i));
      tick();
      chk("rx_simul_count", rx_count, 3);
    end
    uart_rx_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    cpu_rx_ready = 0;
    chk("rx_simul_drained", rx_count, 0);
    // reset during TX_SEND with 4 queued
    for (int i = 0; i < 5; i++) begin
      cpu_tx_data = 8'hC0 + 8'(i); cpu_tx_valid = 1;
      tick();
    end
    cpu_tx_valid = 0;
    chk("pre_rst_send", {uart_tx_valid, tx_count}, {1'b1, 4'd4});
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valid", uart_tx_valid, 0);
    chk("rst_mid_counts", {tx_count, rx_count}, 0);
    tick();
    rst_n = 1;
    uart_tx_ready = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("no_stale", uart_tx_valid, 0);
    end
    uart_tx_ready = 0;
    chk("tx_q_empty", tx_q.size(), 0);
    chk("rx_q_empty", rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
